scan_chain_ctrl: RTL and testbench

SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

---
 rtl/scan_ctrl_pkg.sv | 18 +
 rtl/scan_shreg.sv | 24 ++
 rtl/scan_chain_ctrl.sv | 149 ++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/scan_ctrl_pkg.sv
// Shared types and sizing helpers for the scan chain controller.
package scan_ctrl_pkg;

    localparam int CHAIN_LEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPTURE,
        UNLOAD,
        DONE
    } scan_state_t;

    function automatic int count_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_shreg.sv
// Parallel-load, left-shifting register; the MSB is the serial output end.
module scan_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             CP,
    input  logic             CDN,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] pin,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            q <= '0;
        end else if (load) begin
            q <= pin;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], sin};
        end
    end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan test sequencer: serially loads a pattern, pulses one capture cycle,
// then unloads the chain while comparing each bit against a masked expectation.
module scan_chain_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT
) (
    input  logic                           CP,
    input  logic                           CDN,
    input  logic                           start,
    input  logic [CHAIN_LEN-1:0]           pat_in,
    input  logic [CHAIN_LEN-1:0]           exp_in,
    input  logic [CHAIN_LEN-1:0]           mask_in,
    input  logic                           so,
    output logic                           se,
    output logic                           si,
    output logic                           busy,
    output logic                           done,
    output logic                           fail,
    output logic [$clog2(CHAIN_LEN+1)-1:0] err_cnt,
    output logic [CHAIN_LEN-1:0]           resp_out
);

    localparam int CW = count_width(CHAIN_LEN);
    localparam int EW = $clog2(CHAIN_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LEN - 1);
    localparam logic [EW-1:0] ERR_MAX  = EW'(CHAIN_LEN);

    scan_state_t state, next_state;
    logic [CW-1:0] cnt;
    logic armed, accept, last_shift, mismatch;
    logic in_load, in_unload;
    logic se_nxt, busy_nxt, done_nxt;
    logic [CHAIN_LEN-1:0] ser_q, exp_r, mask_r;
    logic unused_ser_bits;

    assign accept     = (state == IDLE) && start && armed;
    assign last_shift = (cnt == CNT_LAST);
    assign in_load    = (state == LOAD);
    assign in_unload  = (state == UNLOAD);

    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            state <= IDLE;
            se    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            se    <= se_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = LOAD;
            LOAD:    if (last_shift) next_state = CAPTURE;
            CAPTURE: next_state = UNLOAD;
            UNLOAD:  if (last_shift) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state.
    always_comb begin
        se_nxt   = (next_state == LOAD) || (next_state == UNLOAD);
        busy_nxt = (next_state != IDLE);
        done_nxt = (next_state == DONE);
    end

    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            cnt <= '0;
        end else if ((in_load || in_unload) && !last_shift) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    // Holds off start until one clock edge has passed after reset release.
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            exp_r  <= '0;
            mask_r <= '0;
        end else if (accept) begin
            exp_r  <= exp_in;
            mask_r <= mask_in;
        end else if (in_unload) begin
            exp_r  <= {exp_r[CHAIN_LEN-2:0], 1'b0};
            mask_r <= {mask_r[CHAIN_LEN-2:0], 1'b0};
        end
    end

    // An unknown so fails the equality test and is therefore counted as a mismatch.
    always_comb begin
        mismatch = mask_r[CHAIN_LEN-1];
        if (so == exp_r[CHAIN_LEN-1]) mismatch = 1'b0;
    end

    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            fail    <= 1'b0;
            err_cnt <= '0;
        end else if (accept) begin
            fail    <= 1'b0;
            err_cnt <= '0;
        end else if (in_unload && mismatch) begin
            fail <= 1'b1;
            if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
        end
    end

    scan_shreg #(.WIDTH(CHAIN_LEN)) u_pat_ser (
        .CP    (CP),
        .CDN   (CDN),
        .load  (accept),
        .shift (in_load),
        .pin   (pat_in),
        .sin   (1'b0),
        .q     (ser_q)
    );

    scan_shreg #(.WIDTH(CHAIN_LEN)) u_resp_deser (
        .CP    (CP),
        .CDN   (CDN),
        .load  (1'b0),
        .shift (in_unload),
        .pin   ('0),
        .sin   (so),
        .q     (resp_out)
    );

    assign si              = ser_q[CHAIN_LEN-1];
    assign unused_ser_bits = ^ser_q[CHAIN_LEN-2:0];

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl driving an 8-flop chain whose D is tied to QN,
// so every capture cycle inverts the loaded pattern.
module tb_scan_chain_ctrl;

    localparam int N = 8;

    logic         CP = 1'b0;
    logic         CDN = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] pat_in = '0;
    logic [N-1:0] exp_in = '0;
    logic [N-1:0] mask_in = '0;
    logic         so;
    logic         se, si, busy, done, fail;
    logic [3:0]   err_cnt;
    logic [N-1:0] resp_out;
    logic [N-1:0] chain = '0;

    int checks = 0;
    int errors = 0;

    scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
        .CP       (CP),
        .CDN      (CDN),
        .start    (start),
        .pat_in   (pat_in),
        .exp_in   (exp_in),
        .mask_in  (mask_in),
        .so       (so),
        .se       (se),
        .si       (si),
        .busy     (busy),
        .done     (done),
        .fail     (fail),
        .err_cnt  (err_cnt),
        .resp_out (resp_out)
    );

    always #5 CP = ~CP;

    always @(posedge CP) begin
        if (se) chain <= {chain[N-2:0], si};
        else    chain <= ~chain;
    end
    assign so = chain[N-1];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // One full test: expected results come from the chain's inversion rule and a popcount.
    task automatic applyStimulus(input string name, input logic [N-1:0] pat,
                                 input logic [N-1:0] expv, input logic [N-1:0] mask,
                                 input bit glitch);
        logic [N-1:0] ref_resp, loaded, resp_seen;
        int           ref_errs, done_k, done_cnt, se_cnt, busy_cnt;
        logic         fail_seen;
        logic [3:0]   err_seen;
        ref_resp  = ~pat;
        ref_errs  = $countones((ref_resp ^ expv) & mask);
        loaded    = '0;
        resp_seen = '0;
        fail_seen = 1'b0;
        err_seen  = 4'hF;
        done_k    = 0;
        done_cnt  = 0;
        se_cnt    = 0;
        busy_cnt  = 0;
        @(negedge CP);
        pat_in  = pat;
        exp_in  = expv;
        mask_in = mask;
        start   = 1'b1;
        @(posedge CP);
        for (int k = 1; k <= 2*N + 6; k++) begin
            @(negedge CP);
            start = glitch && (k == 3 || k == 2*N + 2);
            if (se) se_cnt++;
            if (busy) busy_cnt++;
            if (se && k <= N) loaded = {loaded[N-2:0], si};
            if (done) begin
                done_cnt++;
                if (done_k == 0) begin
                    done_k    = k;
                    resp_seen = resp_out;
                    fail_seen = fail;
                    err_seen  = err_cnt;
                end
            end
        end
        checkOutput({name, ".done_latency"}, done_k, 2*N + 2);
        checkOutput({name, ".done_pulses"}, done_cnt, 1);
        checkOutput({name, ".se_cycles"}, se_cnt, 2*N);
        checkOutput({name, ".busy_cycles"}, busy_cnt, 2*N + 2);
        checkOutput({name, ".si_stream"}, loaded, pat);
        checkOutput({name, ".resp_out"}, resp_seen, ref_resp);
        checkOutput({name, ".fail"}, fail_seen, (ref_errs != 0));
        checkOutput({name, ".err_cnt"}, err_seen, ref_errs);
        checkOutput({name, ".fail_hold"}, fail, (ref_errs != 0));
        checkOutput({name, ".err_hold"}, err_cnt, ref_errs);
        checkOutput({name, ".idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        int done_seen;
        logic [N-1:0] rp, re, rm;

        repeat (3) @(negedge CP);
        checkOutput("reset.se", se, 1'b0);
        checkOutput("reset.si", si, 1'b0);
        checkOutput("reset.busy", busy, 1'b0);
        checkOutput("reset.done", done, 1'b0);
        checkOutput("reset.fail", fail, 1'b0);
        checkOutput("reset.err_cnt", err_cnt, 0);
        checkOutput("reset.resp_out", resp_out, 0);

        pat_in  = 8'hA5;
        exp_in  = 8'h5A;
        mask_in = 8'hFF;
        CDN     = 1'b1;
        start   = 1'b1;
        @(negedge CP);
        checkOutput("release.first_edge_busy", busy, 1'b0);
        start = 1'b0;
        repeat (3) @(negedge CP);
        checkOutput("release.still_idle", busy, 1'b0);

        applyStimulus("basic", 8'hA5, 8'h5A, 8'hFF, 1'b0);
        applyStimulus("one_bad", 8'hA5, 8'h5B, 8'hFF, 1'b0);
        applyStimulus("one_masked", 8'hA5, 8'h5B, 8'hFE, 1'b0);
        applyStimulus("all_bad", 8'h00, 8'h00, 8'hFF, 1'b0);
        applyStimulus("start_ignored", 8'hA5, 8'h5A, 8'hFF, 1'b1);

        // Abort during the fifth load cycle.
        @(negedge CP);
        start = 1'b1;
        @(posedge CP);
        @(negedge CP);
        start = 1'b0;
        repeat (4) @(negedge CP);
        CDN = 1'b0;
        #1;
        checkOutput("abort.se", se, 1'b0);
        checkOutput("abort.busy", busy, 1'b0);
        checkOutput("abort.si", si, 1'b0);
        done_seen = 0;
        repeat (2) @(negedge CP);
        CDN = 1'b1;
        for (int k = 0; k < 2*N + 6; k++) begin
            @(negedge CP);
            if (done) done_seen++;
        end
        checkOutput("abort.no_done", done_seen, 0);
        checkOutput("abort.idle", busy, 1'b0);
        applyStimulus("after_abort", 8'hA5, 8'h5A, 8'hFF, 1'b0);

        for (int t = 0; t < 6; t++) begin
            rp = N'($urandom);
            re = N'($urandom);
            rm = N'($urandom);
            if (t == 0) re = ~rp;
            applyStimulus($sformatf("rand%0d", t), rp, re, rm, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
